fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have the parameter PC_W, default 10, meaning the program counter width (instruction memory depth 2^PC_W).
REQ-002 The block SHALL have the port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port Reset_n  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have the port Start  input  1  begin program execution; a level, sampled each cycle.
REQ-005 The block SHALL have the port BrValid  input  1  a branch op (BRC/BRR/BRO) is executing this cycle.
REQ-006 The block SHALL have the port bOFFSET  input  9  unsigned branch distance from the ALU.
REQ-007 The block SHALL have the port bSIGN  input  1  branch direction from the ALU; 1 = backward.
REQ-008 The block SHALL have the port SoftReset  input  1  ALU reset request (RST op).
REQ-009 The block SHALL have the port Halt  input  1  ALU halt request (RST op with toggle bit set).
REQ-010 The block SHALL have the port PC  output  PC_W  instruction memory address.
REQ-011 The block SHALL have the port Fetch_en  output  1  the instruction at PC is valid this cycle.
REQ-012 The block SHALL have the port Done  output  1  the program has halted.
REQ-013 The block SHALL have the port InstCount  output  16  count of executed instructions.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 Fetch_en SHALL be 1 only in RUN; Done SHALL be 1 only in DONE; both SHALL be registered outputs.
REQ-016 IDLE + Start=1 SHALL go to RUN on the next edge with PC=0, so the first fetch of PC 0 occurs one cycle after Start is sampled.
REQ-017 In RUN, Start SHALL be ignored.
REQ-018 In RUN, next-PC priority SHALL be: (a) SoftReset&Halt, (b) SoftReset, (c) Halt, (d) BrValid, (e) otherwise.
REQ-019 Priority case (a), SoftReset&Halt, SHALL go to DONE with PC held.
REQ-020 Priority case (b), SoftReset alone, SHALL set PC to 0 and stay in RUN.
REQ-021 Priority case (c), Halt alone, SHALL go to DONE with PC held.
REQ-022 Priority case (d), BrValid, SHALL set PC to PC+bOFFSET when bSIGN=0 and to PC-bOFFSET when bSIGN=1.
REQ-023 Priority case (e), otherwise, SHALL set PC to PC+1.
REQ-024 Branch arithmetic SHALL be done at PC_W+1 bits and truncated to PC_W, wrapping modulo 2^PC_W in both directions.
REQ-025 bOFFSET wider than PC_W SHALL still be added in full before truncation.
REQ-026 bOFFSET=0 with BrValid SHALL leave PC unchanged (self-loop), whatever bSIGN is.
REQ-027 PC=2^PC_W-1 with sequential increment SHALL wrap PC to 0 and stay in RUN.
REQ-028 BrValid, bOFFSET, bSIGN, SoftReset and Halt SHALL be ignored in IDLE and DONE.
REQ-029 DONE + Start=1 SHALL go to RUN with PC=0 on the next edge (next program).
REQ-030 DONE + Start=0 SHALL hold DONE, with PC and InstCount frozen.

Reset
REQ-031 Reset_n=0 at a rising edge SHALL force IDLE, PC=0, Fetch_en=0, Done=0 and InstCount=0, regardless of any other input.
REQ-032 Reset_n low mid-RUN SHALL abort the program with no further PC update, and the block SHALL then wait in IDLE for Start.
REQ-033 Reset_n SHALL have priority over every other input, including Start on the same edge.

Configuration
REQ-034 The macro INST_COUNT_EN, when defined, SHALL make InstCount increment by 1 on every RUN-state edge that retires an instruction (every RUN edge, including the halting one).
REQ-035 With INST_COUNT_EN defined, InstCount SHALL saturate at 16'hFFFF and SHALL clear to 0 on each IDLE/DONE-to-RUN transition.
REQ-036 With INST_COUNT_EN undefined, the InstCount port SHALL still exist, SHALL be tied to 16'h0000, and no counter logic SHALL be present.

Verification
REQ-037 The bench SHALL cover: Reset_n=0 for 2 cycles, then Start pulse -> PC=0 with Fetch_en=1 the following cycle; PC increments 0,1,2,3 on successive cycles.
REQ-038 The bench SHALL cover: PC=20, BrValid=1, bOFFSET=5, bSIGN=1 -> PC=15 next cycle; then PC=15, bOFFSET=9'd300, bSIGN=0 -> PC=315.
REQ-039 The bench SHALL cover: PC=3, BrValid=1, bOFFSET=9'd10, bSIGN=1 -> PC=1017 (wrap); then PC=1023 with no branch -> PC=0.
REQ-040 The bench SHALL cover: SoftReset=1, Halt=0, BrValid=1 at PC=40 -> PC=0 and still RUN; then SoftReset=1, Halt=1 at PC=7 -> Done=1, Fetch_en=0, PC stays 7 for 10 cycles.
REQ-041 The bench SHALL cover: in DONE, Start=1 -> PC=0 with RUN next cycle; with INST_COUNT_EN, InstCount reads 0 on entry and 3 after 3 RUN cycles.
REQ-042 The bench SHALL cover: Reset_n=0 asserted in RUN at PC=50 with BrValid=1 -> next cycle IDLE, PC=0, Fetch_en=0, Done=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: IDLE/RUN/DONE control with branch, soft-reset and halt handling.
// Optional instruction counter is built when the INST_COUNT_EN macro is defined.
module fetch_ctrl #(
   parameter int PC_W = 10
) (
   input  logic            CLK,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            BrValid,
   input  logic [8:0]      bOFFSET,
   input  logic            bSIGN,
   input  logic            SoftReset,
   input  logic            Halt,
   output logic [PC_W-1:0] PC,
   output logic            Fetch_en,
   output logic            Done,
   output logic [15:0]     InstCount
);

   // Sum width covers both PC_W+1 and the full 9-bit offset.
   localparam int SUM_W = ((PC_W + 1) > 10) ? (PC_W + 1) : 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fetch_en_q, fetch_en_d;
   logic            done_q, done_d;
   logic [SUM_W-1:0] pc_ext_s, off_ext_s;
   logic [PC_W-1:0] pc_br_s;

   // Branch target, computed wide and truncated so it wraps in both directions.
   always_comb begin
      pc_ext_s  = SUM_W'(pc_q);
      off_ext_s = SUM_W'(bOFFSET);
      if (bSIGN) begin
         pc_br_s = PC_W'(pc_ext_s - off_ext_s);
      end else begin
         pc_br_s = PC_W'(pc_ext_s + off_ext_s);
      end
   end

   // State and registered outputs.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         fetch_en_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_en_q <= fetch_en_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic; any Halt in RUN ends the program.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (Halt) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (Start) begin
               state_d = RUN;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next PC and output flags, decoded from the upcoming state.
   always_comb begin
      pc_d       = pc_q;
      fetch_en_d = (state_d == RUN);
      done_d     = (state_d == DONE);
      case (state_q)
         RUN: begin
            if (SoftReset && Halt) begin
               pc_d = pc_q;
            end else if (SoftReset) begin
               pc_d = '0;
            end else if (Halt) begin
               pc_d = pc_q;
            end else if (BrValid) begin
               pc_d = pc_br_s;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         IDLE, DONE: begin
            if (Start) begin
               pc_d = '0;
            end else begin
               pc_d = pc_q;
            end
         end
         default: pc_d = '0;
      endcase
   end

   assign PC       = pc_q;
   assign Fetch_en = fetch_en_q;
   assign Done     = done_q;

`ifdef INST_COUNT_EN
   logic [15:0] inst_count_q, inst_count_d;

   // Saturating retire counter, cleared whenever a new program starts.
   always_comb begin
      inst_count_d = inst_count_q;
      if (state_q == RUN) begin
         if (inst_count_q != 16'hFFFF) begin
            inst_count_d = inst_count_q + 16'd1;
         end else begin
            inst_count_d = inst_count_q;
         end
      end else if (state_d == RUN) begin
         inst_count_d = 16'h0000;
      end else begin
         inst_count_d = inst_count_q;
      end
   end

   // Counter register.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         inst_count_q <= 16'h0000;
      end else begin
         inst_count_q <= inst_count_d;
      end
   end

   assign InstCount = inst_count_q;
`else
   assign InstCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl (PC_W = 10), plus hand sequences for reset in RUN.
module tb_fetch_ctrl;

   logic        CLK;
   logic        Reset_n;
   logic        Start;
   logic        BrValid;
   logic [8:0]  bOFFSET;
   logic        bSIGN;
   logic        SoftReset;
   logic        Halt;
   logic [9:0]  PC;
   logic        Fetch_en;
   logic        Done;
   logic [15:0] InstCount;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_ctrl #(.PC_W(10)) dut (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .BrValid   (BrValid),
      .bOFFSET   (bOFFSET),
      .bSIGN     (bSIGN),
      .SoftReset (SoftReset),
      .Halt      (Halt),
      .PC        (PC),
      .Fetch_en  (Fetch_en),
      .Done      (Done),
      .InstCount (InstCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst_n;
      logic        st;
      logic        bv;
      logic [8:0]  off;
      logic        sg;
      logic        sr;
      logic        ht;
      logic [9:0]  pc;
      logic        fe;
      logic        dn;
      logic [15:0] cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rst_n, input logic st, input logic bv,
                               input logic [8:0] off, input logic sg, input logic sr,
                               input logic ht, input logic [9:0] pc, input logic fe,
                               input logic dn, input logic [15:0] cnt);
      vec_t v;
      v.rst_n = rst_n; v.st = st; v.bv = bv; v.off = off; v.sg = sg;
      v.sr = sr; v.ht = ht; v.pc = pc; v.fe = fe; v.dn = dn; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one vector, clock it in, then compare 1 time unit after the edge.
   task automatic apply(input vec_t v, input int idx);
      logic [15:0] exp_cnt;
      Reset_n = v.rst_n; Start = v.st; BrValid = v.bv; bOFFSET = v.off;
      bSIGN = v.sg; SoftReset = v.sr; Halt = v.ht;
      @(posedge CLK);
      #1;
`ifdef INST_COUNT_EN
      exp_cnt = v.cnt;
`else
      exp_cnt = 16'h0000;
`endif
      check($sformatf("pc[%0d]", idx), {6'd0, PC}, {6'd0, v.pc});
      check($sformatf("fetch_en[%0d]", idx), {15'd0, Fetch_en}, {15'd0, v.fe});
      check($sformatf("done[%0d]", idx), {15'd0, Done}, {15'd0, v.dn});
      check($sformatf("inst_count[%0d]", idx), InstCount, exp_cnt);
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; BrValid = 1'b0; bOFFSET = 9'd0;
      bSIGN = 1'b0; SoftReset = 1'b0; Halt = 1'b0;

      //          rst  st   bv   off      sg   sr   ht   pc        fe   dn   cnt
      vq.push_back(mk(1'b0,1'b1,1'b1,9'd5,  1'b0,1'b1,1'b1,10'd0,   1'b0,1'b0,16'd0));
      vq.push_back(mk(1'b0,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd0,   1'b0,1'b0,16'd0));
      vq.push_back(mk(1'b1,1'b1,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd0,   1'b1,1'b0,16'd0));
      vq.push_back(mk(1'b1,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd1,   1'b1,1'b0,16'd1));
      vq.push_back(mk(1'b1,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd2,   1'b1,1'b0,16'd2));
      vq.push_back(mk(1'b1,1'b1,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd3,   1'b1,1'b0,16'd3));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd17, 1'b0,1'b0,1'b0,10'd20,  1'b1,1'b0,16'd4));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd5,  1'b1,1'b0,1'b0,10'd15,  1'b1,1'b0,16'd5));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd300,1'b0,1'b0,1'b0,10'd315, 1'b1,1'b0,16'd6));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd312,1'b1,1'b0,1'b0,10'd3,   1'b1,1'b0,16'd7));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd10, 1'b1,1'b0,1'b0,10'd1017,1'b1,1'b0,16'd8));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd6,  1'b0,1'b0,1'b0,10'd1023,1'b1,1'b0,16'd9));
      vq.push_back(mk(1'b1,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd0,   1'b1,1'b0,16'd10));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd40, 1'b0,1'b0,1'b0,10'd40,  1'b1,1'b0,16'd11));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd5,  1'b0,1'b1,1'b0,10'd0,   1'b1,1'b0,16'd12));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd7,  1'b0,1'b0,1'b0,10'd7,   1'b1,1'b0,16'd13));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd3,  1'b0,1'b1,1'b1,10'd7,   1'b0,1'b1,16'd14));
      // DONE holds for 10 cycles while branch/reset/halt inputs toggle.
      for (int k = 0; k < 10; k++) begin
         vq.push_back(mk(1'b1, 1'b0, k[0], 9'(k * 37), k[1], k[2], k[0] ^ k[1],
                         10'd7, 1'b0, 1'b1, 16'd14));
      end
      vq.push_back(mk(1'b1,1'b1,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd0,   1'b1,1'b0,16'd0));
      vq.push_back(mk(1'b1,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd1,   1'b1,1'b0,16'd1));
      vq.push_back(mk(1'b1,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd2,   1'b1,1'b0,16'd2));
      vq.push_back(mk(1'b1,1'b0,1'b0,9'd0,  1'b0,1'b0,1'b0,10'd3,   1'b1,1'b0,16'd3));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd0,  1'b1,1'b0,1'b0,10'd3,   1'b1,1'b0,16'd4));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd0,  1'b0,1'b0,1'b0,10'd3,   1'b1,1'b0,16'd5));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd9,  1'b0,1'b0,1'b1,10'd3,   1'b0,1'b1,16'd6));
      vq.push_back(mk(1'b1,1'b0,1'b1,9'd9,  1'b0,1'b1,1'b1,10'd3,   1'b0,1'b1,16'd6));

      for (int i = 0; i < vq.size(); i++) begin
         apply(vq[i], i);
      end

      // Reset asserted mid-RUN at PC=50 with a branch pending, then waiting in IDLE.
      apply(mk(1'b1,1'b1,1'b0,9'd0, 1'b0,1'b0,1'b0,10'd0, 1'b1,1'b0,16'd0), 100);
      apply(mk(1'b1,1'b0,1'b1,9'd50,1'b0,1'b0,1'b0,10'd50,1'b1,1'b0,16'd1), 101);
      apply(mk(1'b0,1'b1,1'b1,9'd4, 1'b0,1'b0,1'b0,10'd0, 1'b0,1'b0,16'd0), 102);
      apply(mk(1'b1,1'b0,1'b1,9'd4, 1'b0,1'b1,1'b1,10'd0, 1'b0,1'b0,16'd0), 103);
      apply(mk(1'b1,1'b0,1'b0,9'd0, 1'b0,1'b0,1'b0,10'd0, 1'b0,1'b0,16'd0), 104);
      apply(mk(1'b1,1'b1,1'b0,9'd0, 1'b0,1'b0,1'b0,10'd0, 1'b1,1'b0,16'd0), 105);
      apply(mk(1'b1,1'b0,1'b0,9'd0, 1'b0,1'b0,1'b0,10'd1, 1'b1,1'b0,16'd1), 106);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
